// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
package rsa_pkg;

    localparam int unsigned DEF_WIDTH = 6;
    localparam int unsigned CNT_W     = $clog2(2 * DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width needed to index every bit of a 2*w-bit product.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One restoring shift-subtract step: shifts the next product bit into the
// running remainder and subtracts the modulus when it fits.
module mod_sub_step
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] r_next
);

    logic [WIDTH:0] t;

    // Compare the widened trial value against the modulus; since r < n the
    // difference always fits back into WIDTH bits.
    always_comb begin
        t = {r, bit_in};
        if (t >= {1'b0, n}) begin
            r_next = WIDTH'(t - {1'b0, n});
        end else begin
            r_next = WIDTH'(t);
        end
    end

endmodule

// File: rtl/mod_reduce.sv
// Sequential modular reducer: remainder = product mod modulus, computed one
// product bit per clock by restoring shift-subtract.
module mod_reduce
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] product,
    input  logic [WIDTH-1:0]   modulus,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH-1:0]   remainder,
    output logic               err
);

    localparam int unsigned     CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(2 * WIDTH - 1);

    state_t               state;
    state_t               state_next;
    logic                 accept;

    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     n;
    // The accumulator's top compare bit exists only inside the step logic;
    // between steps r < n always holds, so WIDTH bits are stored.
    logic [WIDTH-1:0]     r;
    logic [WIDTH-1:0]     r_next;
    logic [CW-1:0]        cnt;

    mod_sub_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r),
        .bit_in (p[2*WIDTH-1]),
        .n      (n),
        .r_next (r_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (modulus == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (modulus == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, shift-subtract datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p         <= '0;
            n         <= '0;
            r         <= '0;
            cnt       <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else if (accept) begin
            p         <= product;
            n         <= modulus;
            r         <= '0;
            cnt       <= CNT_LAST;
            remainder <= '0;
            err       <= (modulus == '0);
        end else if (state == RUN) begin
            r   <= r_next;
            p   <= {p[2*WIDTH-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                remainder <= r_next;
            end
        end
    end

endmodule

// File: tb/tb_mod_reduce.sv
// Scoreboard bench for mod_reduce with WIDTH=6 and directed vectors.
module tb_mod_reduce;

    localparam int unsigned W = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2*W-1:0]   product;
    logic [W-1:0]     modulus;
    logic             busy;
    logic             valid;
    logic [W-1:0]     remainder;
    logic             err;

    typedef struct {
        int unsigned rem;
        bit          err;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    mod_reduce #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .product   (product),
        .modulus   (modulus),
        .busy      (busy),
        .valid     (valid),
        .remainder (remainder),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid cycle must match the oldest expected result,
    // including the cycle in which it appears.
    always @(negedge clk) begin
        if (!rst && valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid cyc=%0d rem=%0d err=%0d required=no valid", cyc, remainder, err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (remainder != W'(e.rem) || err != e.err || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL result got rem=%0d err=%0d cyc=%0d required rem=%0d err=%0d cyc=%0d",
                             remainder, err, cyc, e.rem, e.err, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Called just after a negedge; holds start for exactly one rising edge.
    task automatic issue(input int unsigned prod, input int unsigned mdl,
                         input int unsigned rem, input bit e);
        exp_t x;
        product = (2*W)'(prod);
        modulus = W'(mdl);
        start   = 1'b1;
        x.rem   = rem;
        x.err   = e;
        x.cyc   = cyc + 1 + (e ? 0 : 2*W);
        q.push_back(x);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (valid) found = 1'b1;
        end
        check({name, "_timeout"}, int'(found), 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        product  = '0;
        modulus  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_remainder", int'(remainder), 0);

        // 3233 mod 55 with busy profile
        issue(3233, 55, 43, 0);
        for (int i = 0; i < 2*W; i++) begin
            @(negedge clk);
            check("busy_run", int'(busy), 1);
        end
        wait_valid("basic");
        check("busy_in_valid", int'(busy), 0);

        @(negedge clk);
        check("valid_one_cycle", int'(valid), 0);
        issue(4095, 63, 0, 0);
        wait_valid("max_product");
        @(negedge clk);
        issue(17, 55, 17, 0);
        wait_valid("small_product");
        @(negedge clk);
        issue(2000, 1, 0, 0);
        wait_valid("mod_one");
        @(negedge clk);
        issue(555, 0, 0, 1);
        wait_valid("mod_zero");
        check("mod_zero_busy", int'(busy), 0);

        // back-to-back: new start in the DONE cycle
        @(negedge clk);
        issue(2047, 32, 31, 0);
        wait_valid("b2b_first");
        issue(100, 7, 2, 0);
        wait_valid("b2b_second");

        // reset in the middle of RUN aborts the operation
        @(negedge clk);
        issue(3233, 55, 43, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        void'(q.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_err", int'(err), 0);
        check("abort_remainder", int'(remainder), 0);
        repeat (16) @(negedge clk);
        issue(3233, 55, 43, 0);
        wait_valid("after_abort");

        // start during RUN is ignored
        @(negedge clk);
        issue(3233, 55, 43, 0);
        repeat (3) @(negedge clk);
        product = 12'd100;
        modulus = 6'd7;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid("start_in_run");

        // further boundaries
        @(negedge clk);
        issue(4095, 62, 3, 0);
        wait_valid("mod_62");
        @(negedge clk);
        issue(0, 63, 0, 0);
        wait_valid("zero_product");
        @(negedge clk);
        issue(4095, 1, 0, 0);
        wait_valid("max_mod_one");

        repeat (20) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
